user_mgr_arbiter: RTL

Round-robin OBI manager arbiter for the user domain. It merges NumMgr user-domain OBI managers (the CNN accelerator's memory port plus future DMA/debug masters) onto the single user manager port that leaves the user domain toward the Croc crossbar. It holds each request stable until granted and tracks outstanding transactions in order. It routes every response back to the manager that issued the request.

---
 rtl/user_mgr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/user_mgr_arbiter.sv
// Round-robin OBI manager arbiter: merges NumMgr upstream managers onto one
// downstream port and routes responses back in order through an ID FIFO.
module user_mgr_arbiter #(
   parameter int  NumMgr   = 2,
   parameter int  MaxTrans = 4,
   localparam int IdW      = (NumMgr > 1) ? $clog2(NumMgr) : 1,
   localparam int CntW     = $clog2(MaxTrans + 1),
   localparam int PtrW     = (MaxTrans > 1) ? $clog2(MaxTrans) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumMgr-1:0]    mgr_req_i,
   input  logic [NumMgr*32-1:0] mgr_addr_i,
   input  logic [NumMgr-1:0]    mgr_we_i,
   input  logic [NumMgr*4-1:0]  mgr_be_i,
   input  logic [NumMgr*32-1:0] mgr_wdata_i,
   output logic [NumMgr-1:0]    mgr_gnt_o,
   output logic [NumMgr-1:0]    mgr_rvalid_o,
   output logic [31:0]          mgr_rdata_o,
   output logic                 mgr_err_o,
   output logic                 out_req_o,
   output logic [31:0]          out_addr_o,
   output logic                 out_we_o,
   output logic [3:0]           out_be_o,
   output logic [31:0]          out_wdata_o,
   input  logic                 out_gnt_i,
   input  logic                 out_rvalid_i,
   input  logic [31:0]          out_rdata_i,
   input  logic                 out_err_i,
   output logic [CntW-1:0]      outstanding_o,
   output logic                 protocol_err_o
);

   typedef enum logic {ARB, HOLD} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } a_req_t;

   a_req_t [NumMgr-1:0] a_req;

   for (genvar k = 0; k < NumMgr; k++) begin : g_unpack
      assign a_req[k].addr  = mgr_addr_i[32*k +: 32];
      assign a_req[k].we    = mgr_we_i[k];
      assign a_req[k].be    = mgr_be_i[4*k +: 4];
      assign a_req[k].wdata = mgr_wdata_i[32*k +: 32];
   end

   state_t                          state, state_nxt;
   logic   [IdW-1:0]                rr_ptr, hold_id;
   logic   [IdW-1:0]                pick, sel;
   logic                            pick_vld, sel_vld, active;
   logic                            push, pop, full, empty, perr;
   logic   [CntW-1:0]               count;
   logic   [PtrW-1:0]               wr_ptr, rd_ptr;
   logic   [MaxTrans-1:0][IdW-1:0]  fifo;
   logic   [IdW-1:0]                head;

   assign full  = (count == CntW'(MaxTrans));
   assign empty = (count == '0);
   assign head  = fifo[rd_ptr];

   // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = NumMgr - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NumMgr) idx = idx - NumMgr;
         if (mgr_req_i[idx]) begin
            pick     = IdW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      sel       = hold_id;
      sel_vld   = 1'b0;
      case (state)
         ARB: begin
            if (pick_vld && !full) begin
               sel     = pick;
               sel_vld = 1'b1;
               if (!out_gnt_i) state_nxt = HOLD;
            end
         end
         HOLD: begin
            sel     = hold_id;
            sel_vld = 1'b1;
            if (out_gnt_i) state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
   end

   // Everything is forced quiet while reset is held.
   assign active = sel_vld & ~rst_i;
   assign push   = active & out_gnt_i;
   assign pop    = out_rvalid_i & ~empty & ~rst_i;

   assign out_req_o    = active;
   assign out_addr_o   = active ? a_req[sel].addr  : '0;
   assign out_we_o     = active ? a_req[sel].we    : 1'b0;
   assign out_be_o     = active ? a_req[sel].be    : '0;
   assign out_wdata_o  = active ? a_req[sel].wdata : '0;
   assign mgr_gnt_o    = push ? (NumMgr'(1) << sel) : '0;

   assign mgr_rvalid_o = pop ? (NumMgr'(1) << head) : '0;
   assign mgr_rdata_o  = (out_rvalid_i && !rst_i) ? out_rdata_i : '0;
   assign mgr_err_o    = out_rvalid_i & out_err_i & ~rst_i;

   assign outstanding_o  = count;
   assign protocol_err_o = perr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ARB;
         hold_id <= '0;
         rr_ptr  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ARB && state_nxt == HOLD) hold_id <= pick;
         if (push) rr_ptr <= (sel == IdW'(NumMgr - 1)) ? '0 : sel + IdW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fifo   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         perr   <= 1'b0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr + PtrW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PtrW'(1);
         case ({push, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
         // A response with nothing outstanding is dropped and flagged until reset.
         if (out_rvalid_i && empty) perr <= 1'b1;
      end
   end

endmodule
